// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard receiver: conditions the raw lines, deframes 11-bit frames and
// emits each validated scan-code byte with single-cycle ready/error strobes.
module ps2_scancode_receiver #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keyData,
    output logic       keyReady,
    output logic       parityErr,
    output logic       frameErr
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]            clk_sync;
    logic [1:0]            data_sync;
    logic [FILTER_LEN-1:0] filt_sr;
    logic                  filt_q;
    logic                  filt_prev;
    logic                  fall;
    logic                  sdata;

    state_t        state, state_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shift, shift_n;
    logic          par_q, par_n;
    logic [TW-1:0] to_cnt, to_cnt_n;
    logic [7:0]    key_data_n;
    logic          key_ready_n, parity_err_n, frame_err_n;

    // Synchronize both lines and debounce the clock line
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            filt_sr   <= '1;
            filt_q    <= 1'b1;
            filt_prev <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            filt_sr   <= {filt_sr[FILTER_LEN-2:0], clk_sync[1]};
            if (filt_sr == '0)
                filt_q <= 1'b0;
            else if (filt_sr == '1)
                filt_q <= 1'b1;
            filt_prev <= filt_q;
        end
    end

    assign fall  = filt_prev & ~filt_q;
    assign sdata = data_sync[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            par_q     <= 1'b0;
            to_cnt    <= '0;
            keyData   <= 8'h00;
            keyReady  <= 1'b0;
            parityErr <= 1'b0;
            frameErr  <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shift     <= shift_n;
            par_q     <= par_n;
            to_cnt    <= to_cnt_n;
            keyData   <= key_data_n;
            keyReady  <= key_ready_n;
            parityErr <= parity_err_n;
            frameErr  <= frame_err_n;
        end
    end

    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        shift_n      = shift;
        par_n        = par_q;
        to_cnt_n     = to_cnt;
        key_data_n   = keyData;
        key_ready_n  = 1'b0;
        parity_err_n = 1'b0;
        frame_err_n  = 1'b0;

        case (state)
            IDLE: begin
                to_cnt_n = '0;
                if (fall && !sdata) begin
                    state_n   = DATA;
                    bit_cnt_n = '0;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_n[bit_cnt] = sdata;
                    bit_cnt_n        = 3'(bit_cnt + 3'd1);
                    if (bit_cnt == 3'd7)
                        state_n = PARITY;
                end
            end
            PARITY: begin
                if (fall) begin
                    par_n   = sdata;
                    state_n = STOP;
                end
            end
            STOP: begin
                // Stop-bit failure outranks a parity failure
                if (fall) begin
                    state_n = IDLE;
                    if (!sdata)
                        frame_err_n = 1'b1;
                    else if (^{shift, par_q}) begin
                        key_data_n  = shift;
                        key_ready_n = 1'b1;
                    end else
                        parity_err_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Mid-frame watchdog; a fall on the terminal count wins
        if (state != IDLE) begin
            if (fall)
                to_cnt_n = '0;
            else if (to_cnt == TO_LAST) begin
                state_n     = IDLE;
                shift_n     = '0;
                to_cnt_n    = '0;
                frame_err_n = 1'b1;
            end else
                to_cnt_n = TW'(to_cnt + TW'(1));
        end
    end

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Randomized bench for ps2_scancode_receiver, checked against a frame-level model.
module tb_ps2_scancode_receiver;

    localparam int unsigned FL = 8;
    localparam int unsigned TO = 1500;
    localparam int unsigned H  = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] keyData;
    logic       keyReady;
    logic       parityErr;
    logic       frameErr;

    int checks = 0;
    int errors = 0;

    int   cyc = 0;
    int   kr_total = 0, pe_total = 0, fe_total = 0;
    int   fe_cyc = 0;
    int   last_fall_cyc = 0;
    logic [7:0] kd_at_ready = 8'h00;
    logic [7:0] exp_data;

    ps2_scancode_receiver #(
        .FILTER_LEN    (FL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .keyData  (keyData),
        .keyReady (keyReady),
        .parityErr(parityErr),
        .frameErr (frameErr)
    );

    always #5 clk = ~clk;

    // Count strobe cycles and capture data at each ready strobe
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (keyReady) begin
            kr_total    <= kr_total + 1;
            kd_at_ready <= keyData;
        end
        if (parityErr) pe_total <= pe_total + 1;
        if (frameErr) begin
            fe_total <= fe_total + 1;
            fe_cyc   <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic ps2_bit(input logic b, input bit glitch);
        ps2_data = b;
        repeat (H / 2) @(posedge clk);
        if (glitch) begin
            ps2_clk = 1'b0;
            repeat (3) @(posedge clk);
            ps2_clk = 1'b1;
            repeat (H / 2 - 3) @(posedge clk);
        end else
            repeat (H / 2) @(posedge clk);
        ps2_clk       = 1'b0;
        last_fall_cyc = cyc;
        repeat (H) @(posedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit glitch);
        logic par;
        par = ~(^b) ^ bad_par;
        ps2_bit(1'b0, glitch);
        for (int i = 0; i < 8; i++)
            ps2_bit(b[i], glitch && (i == 3));
        ps2_bit(par, 1'b0);
        ps2_bit(~bad_stop, glitch);
        ps2_data = 1'b1;
        repeat (60) @(posedge clk);
    endtask

    // Model: a frame yields exactly one outcome, stop failure first, then parity
    task automatic run_frame(input string tag, input logic [7:0] b, input bit bad_par,
                             input bit bad_stop, input bit glitch);
        int kr0, pe0, fe0;
        bit good;
        kr0  = kr_total;
        pe0  = pe_total;
        fe0  = fe_total;
        send_frame(b, bad_par, bad_stop, glitch);
        good = !bad_stop && !bad_par;
        if (good) exp_data = b;
        @(negedge clk);
        check({tag, "_ready_cnt"}, 32'(kr_total - kr0), 32'(good));
        check({tag, "_perr_cnt"}, 32'(pe_total - pe0), 32'(!bad_stop && bad_par));
        check({tag, "_ferr_cnt"}, 32'(fe_total - fe0), 32'(bad_stop));
        check({tag, "_keydata"}, 32'(keyData), 32'(exp_data));
        if (good)
            check({tag, "_data_at_strobe"}, 32'(kd_at_ready), 32'(b));
    endtask

    initial begin
        int kr0, pe0, fe0, d;
        logic [7:0] rb;
        int kind;
        rst      = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        exp_data = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_keydata", 32'(keyData), 32'h00);
        check("rst_strobes", 32'({keyReady, parityErr, frameErr}), 32'h0);
        rst = 1'b1;
        repeat (20) @(posedge clk);

        run_frame("d1d", 8'h1D, 1'b0, 1'b0, 1'b0);
        run_frame("df0", 8'hF0, 1'b0, 1'b0, 1'b0);
        run_frame("d23", 8'h23, 1'b0, 1'b0, 1'b0);
        run_frame("d1c_par", 8'h1C, 1'b1, 1'b0, 1'b0);
        run_frame("d1b_stop", 8'h1B, 1'b0, 1'b1, 1'b0);
        run_frame("prio", 8'h5A, 1'b1, 1'b1, 1'b0);
        run_frame("glitch1d", 8'h1D, 1'b0, 1'b0, 1'b1);

        // Abandoned frame: start plus four data bits, then silence
        kr0 = kr_total;
        fe0 = fe_total;
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1, 1'b0);
        ps2_data = 1'b1;
        for (int i = 0; i < int'(TO) + 200 && fe_total == fe0; i++) @(posedge clk);
        @(negedge clk);
        check("timeout_ferr", 32'(fe_total - fe0), 32'd1);
        d = fe_cyc - last_fall_cyc;
        check("timeout_latency_ok", 32'(d >= int'(TO) && d <= int'(TO + FL + 8)), 32'd1);
        check("timeout_no_ready", 32'(kr_total - kr0), 32'd0);
        check("timeout_keydata", 32'(keyData), 32'(exp_data));
        repeat (20) @(posedge clk);
        run_frame("after_to", 8'h1D, 1'b0, 1'b0, 1'b0);

        // Reset mid-frame
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b0, 1'b0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        exp_data = 8'h00;
        check("midrst_keydata", 32'(keyData), 32'(exp_data));
        check("midrst_strobes", 32'({keyReady, parityErr, frameErr}), 32'h0);
        rst = 1'b1;
        kr0 = kr_total;
        pe0 = pe_total;
        fe0 = fe_total;
        repeat (20) @(posedge clk);
        check("midrst_quiet", 32'((kr_total - kr0) + (pe_total - pe0) + (fe_total - fe0)), 32'd0);
        run_frame("after_rst", 8'h1D, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 36; n++) begin
            rb   = 8'($urandom_range(0, 255));
            kind = int'($urandom_range(0, 9));
            run_frame("rand", rb, (kind == 7) || (kind == 9 && rb[0]), kind >= 8,
                      $urandom_range(0, 3) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_receiver.md
Name: ps2_scancode_receiver

Overview:
- Receives PS/2 keyboard frames on the ps2_clk/ps2_data lines and delivers each validated scan-code byte (make codes, 8'hF0 break prefix, 8'hE0 extended prefix) on keyData with a single-cycle keyReady strobe.
- Sits directly upstream of the object movement engine, which acts on any cycle where keyReady is high. The one-cycle strobe width is therefore mandatory.
- Also reports parity and framing faults as single-cycle pulses.

Parameters:
- FILTER_LEN, 8: consecutive identical samples of synchronized ps2_clk required before the filtered clock level changes (range 2..16).
- TIMEOUT_CYCLES, 100000: clk cycles without a filtered ps2_clk falling edge, while mid-frame, after which the frame is aborted. Default is 1 ms at 100 MHz.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- ps2_clk  input  1  raw PS/2 clock from the keyboard, asynchronous.
- ps2_data  input  1  raw PS/2 data from the keyboard, asynchronous.
- keyData  output  8  last valid received byte.
- keyReady  output  1  one-cycle strobe: keyData holds a new byte.
- parityErr  output  1  one-cycle strobe: frame rejected for bad parity.
- frameErr  output  1  one-cycle strobe: frame rejected for bad stop bit or timeout.

Behaviour:
- Reset (rst=0, async):
  - keyData=8'h00; keyReady=parityErr=frameErr=0; state=IDLE.
  - Synchronizer flops, filter shift register and filtered clock all =1; bit counter, shift register and timeout counter =0.
- Input conditioning:
  - Both raw lines pass through a 2-flop synchronizer.
  - The synchronized ps2_clk feeds a FILTER_LEN-deep shift register. The filtered level becomes 0 only when all samples are 0, and becomes 1 only when all samples are 1; otherwise it holds.
  - fall = filtered level was 1 on the previous cycle and is 0 now. All frame bits are sampled from synchronized ps2_data on the cycle fall is asserted.
- Frame format: start(0), d0..d7 LSB first, odd parity, stop(1).
- FSM:
  - IDLE: on fall with data=0, go to DATA with bitcnt=0. On fall with data=1 (bad start), stay in IDLE silently.
  - DATA: on each fall, shift data into bit[bitcnt] and increment bitcnt. After the 8th bit, go to PARITY.
  - PARITY: on fall, store the parity bit and go to STOP.
  - STOP: on fall, evaluate the frame and go to IDLE:
    - stop=1 and (^{byte,parity})==1: keyData<=byte, keyReady=1.
    - stop=1 and parity bad: parityErr=1; keyData unchanged.
    - stop=0: frameErr=1; keyData unchanged. Stop-bit failure takes priority over parity failure.
- Latency: outputs are registered. The strobe is high in the cycle after the final-bit fall cycle, for exactly one cycle, then low.
- Timeout:
  - In DATA, PARITY or STOP, the counter increments every clk and clears on each fall.
  - Reaching TIMEOUT_CYCLES-1 without a fall: frameErr strobe, go to IDLE, discard the partial byte.
  - The counter is held at 0 in IDLE.
  - Counter width is clog2(TIMEOUT_CYCLES+1).
- Simultaneous events: a fall in the same cycle the timeout count is reached is treated as a fall; no timeout occurs.
- Back-to-back frames: a fall arriving in the cycle immediately after STOP completes is accepted as a new start bit.
- No buffering: at most one strobe per frame. A consumer that misses the strobe loses the byte.
- Reset mid-frame: immediate abort with no strobes. The next frame is received normally.
- The block never drives the PS/2 lines (receive only).

Test Plan:
- Send a valid frame for 8'h1D (parity=1, stop=1) at 12.5 kHz -> one keyReady pulse exactly 1 clk wide; keyData=8'h1D; no error strobes.
- Send 8'hF0 then 8'h23 back-to-back -> two keyReady pulses with keyData=8'hF0 then 8'h23. keyData must hold 8'hF0 between the pulses.
- Send 8'h1C with the parity bit inverted -> parityErr pulse 1 clk wide; no keyReady; keyData keeps its previous value (8'h23).
- Send 8'h1B with stop=0 -> frameErr pulse; no keyReady; keyData unchanged.
- Stop clocking after the start bit plus 4 data bits -> frameErr pulse TIMEOUT_CYCLES clk after the last fall. A following valid 8'h1D frame then yields keyReady with keyData=8'h1D.
- Inject 3-clk-wide low glitches on ps2_clk (FILTER_LEN=8) during a valid 8'h1D frame -> glitches ignored, keyData=8'h1D.
- Assert rst low mid-frame -> all outputs return to 0 and keyData reads 8'h00; the next valid frame is received correctly.
